// File: rtl/button_event.sv
// Debounced button level to single-cycle press / release / auto-repeat event pulses.
// Auto-repeat (REPEAT state, hold/repeat counting) is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic move_pulse,
  output logic held
);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      (HOLD_CYCLES >> CNT_W) != 0 || (REPEAT_CYCLES >> CNT_W) != 0) begin : g_param_check
    $error("button_event: HOLD_CYCLES/REPEAT_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StRepeat
  } state_e;

  state_e state_q, state_d;
  logic   lvl_q;
  logic   press_det;
  logic   press_d, release_d, repeat_d, held_d;

`ifdef BUTTON_EVENT_REPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign press_det = btn_level & ~lvl_q;

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    cnt_d     = cnt_q;
`endif
    if (!enable) begin
      // Disable aborts any hold silently; no release pulse.
      state_d = StIdle;
`ifdef BUTTON_EVENT_REPEAT_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (press_det) begin
            press_d = 1'b1;
            state_d = StPressed;
`ifdef BUTTON_EVENT_REPEAT_EN
            cnt_d   = '0;
`endif
          end
        end
        StPressed: begin
          if (!btn_level) begin
            release_d = 1'b1;
            state_d   = StIdle;
`ifdef BUTTON_EVENT_REPEAT_EN
            cnt_d     = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
            state_d  = StRepeat;
          end else begin
            cnt_d = cnt_q + 1'b1;
`endif
          end
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        StRepeat: begin
          // Release wins over a repeat landing on the same edge.
          if (!btn_level) begin
            release_d = 1'b1;
            state_d   = StIdle;
            cnt_d     = '0;
          end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      // Start high so a button held across reset needs a fresh press.
      lvl_q         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      move_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lvl_q         <= btn_level;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
      move_pulse    <= press_d | repeat_d;
      held          <= held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with HOLD_CYCLES=8, REPEAT_CYCLES=4: vector table plus scoreboard queue.
// Repeat expectations follow BUTTON_EVENT_REPEAT_EN exactly as the DUT build does.
module tb_button_event;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  typedef struct packed {
    logic rst;
    logic en;
    logic btn;
    logic p;    // expected press_pulse in the cycle after this edge
    logic rl;   // expected release_pulse
    logic rp;   // expected repeat_pulse
    logic h;    // expected held
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic enable = 1'b1;
  logic press_pulse, release_pulse, repeat_pulse, move_pulse, held;

  int n_cmp = 0;
  int n_bad = 0;
  int vec_idx = 0;

  vec_t vecs[$];
  vec_t sb[$];

  button_event #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (25)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .enable       (enable),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .move_pulse   (move_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic en, input logic b, input logic p,
                              input logic rl, input logic rp, input logic h);
    vec_t v;
    v = '{rst: r, en: en, btn: b, p: p, rl: rl, rp: rp, h: h};
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d t=%0t: got %b expected %b", name, vec_idx, $time, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard empty at vec %0d", vec_idx);
      return;
    end
    e = sb.pop_front();
    cmp("press_pulse", press_pulse, e.p);
    cmp("release_pulse", release_pulse, e.rl);
    cmp("repeat_pulse", repeat_pulse, e.rp);
    cmp("move_pulse", move_pulse, e.p | e.rp);
    cmp("held", held, e.h);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    enable    = v.en;
    btn_level = v.btn;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
    vec_idx++;
  endtask

  initial begin
    vec_t hv;

    // Reset: outputs 0 after each reset edge.
    for (int e = 0; e < 2; e++) add(1, 1, 0, 0, 0, 0, 0);

    // Short press: rise sampled at edge 10, fall at edge 13.
    for (int e = 0; e < 17; e++)
      add(0, 1, (e >= 10 && e < 13), (e == 10), (e == 13), 0, (e >= 10 && e < 13));

    // Long hold: 30 cycles; repeats in cycles 19,23,...,39 (outputs after edges 18,22,...,38).
    for (int e = 0; e < 46; e++)
      add(0, 1, (e >= 10 && e < 40), (e == 10), (e == 40),
          RepEn && e >= 18 && e < 40 && ((e - 18) % 4 == 0), (e >= 10 && e < 40));

    // Release on the edge that would otherwise fire the first repeat.
    for (int e = 0; e < 22; e++)
      add(0, 1, (e >= 10 && e < 18), (e == 10), (e == 18), 0, (e >= 10 && e < 18));

    // Held across reset (edges 5-6): no press until release and re-press.
    for (int e = 0; e < 23; e++) begin
      logic b;
      b = (e < 12) || (e >= 14 && e < 20);
      add((e == 5 || e == 6), 1, b, (e == 0 || e == 14), (e == 20), 0,
          (e < 5) || (e >= 14 && e < 20));
    end

    // Disable 3 cycles after the press while held, re-enable, then fresh press.
    for (int e = 0; e < 18; e++) begin
      logic b;
      b = (e < 13) || (e == 14);
      add(0, !(e >= 3 && e < 8), b, (e == 0 || e == 14), (e == 15), 0,
          (e < 3) || (e == 14));
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Hand sequence: rising edge sampled while disabled is lost; needs a fresh press.
    hv = '{rst: 0, en: 0, btn: 1, p: 0, rl: 0, rp: 0, h: 0};
    apply(hv);
    apply(hv);
    hv.en = 1;
    for (int i = 0; i < 3; i++) apply(hv);
    hv.btn = 0;
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 1, p: 1, rl: 0, rp: 0, h: 1};
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 1, p: 0, rl: 0, rp: 0, h: 1};
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 0, p: 0, rl: 1, rp: 0, h: 0};
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 0, p: 0, rl: 0, rp: 0, h: 0};
    apply(hv);

    // Hand sequence: release sampled on the edge right after the press.
    hv = '{rst: 0, en: 1, btn: 1, p: 1, rl: 0, rp: 0, h: 1};
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 0, p: 0, rl: 1, rp: 0, h: 0};
    apply(hv);
    hv = '{rst: 0, en: 1, btn: 0, p: 0, rl: 0, rp: 0, h: 0};
    apply(hv);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard leftover entries: got %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
